// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
//   Owns the fetch PC, issues word reads to instruction memory, tracks the
//   PC of every in-flight read, buffers returned words in an in-order FIFO
//   and presents {instr, instr_pc} to the decoder over valid/ready.
//   A redirect flushes buffered words and discards responses still owed
//   for requests issued before it.
//   Build option: define IF_MISALIGN_CHK_EN to turn a misaligned redirect
//   into a single NOP fault beat followed by a fetch halt. Without it
//   fetch_fault is tied low and redirect_pc[1:0] is ignored.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);

   localparam int unsigned   AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned   CW        = $clog2(FIFO_DEPTH + 1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(FIFO_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W   = (CW+1)'(FIFO_DEPTH);
   localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;

   // Circular index increment that wraps at the last buffer entry
   function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] idx);
      logic [AW-1:0] nxt;
      if (idx == LAST_IDX) begin
         nxt = '0;
      end else begin
         nxt = idx + AW'(1);
      end
      return nxt;
   endfunction

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] infl_q, infl_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
   logic [AW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
   logic [31:0]   f_data_q [FIFO_DEPTH];
   logic [31:0]   f_pc_q   [FIFO_DEPTH];
   logic [31:0]   pcq_q    [FIFO_DEPTH];

   logic          halt_s, fault_s;
   logic [31:0]   fault_pc_s;
   logic [31:0]   redirect_tgt_s;
   logic          fifo_nonempty_s, pop_s, push_s, req_fire_s, credit_s;
   logic [CW:0]   used_s;

   assign redirect_tgt_s = {redirect_pc[31:2], 2'b00};

`ifdef IF_MISALIGN_CHK_EN
   logic        fault_pend_q;
   logic        halt_q;
   logic [31:0] fault_pc_q;

   // Misaligned redirect parks one NOP fault beat and halts fetch until the next redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_pend_q <= 1'b0;
         halt_q       <= 1'b0;
         fault_pc_q   <= 32'h0000_0000;
      end else if (redirect_valid) begin
         fault_pend_q <= (redirect_pc[1:0] != 2'b00);
         halt_q       <= (redirect_pc[1:0] != 2'b00);
         fault_pc_q   <= redirect_pc;
      end else if (fault_pend_q && instr_ready) begin
         fault_pend_q <= 1'b0;
      end else begin
         fault_pend_q <= fault_pend_q;
      end
   end

   assign halt_s     = halt_q;
   assign fault_s    = fault_pend_q;
   assign fault_pc_s = fault_pc_q;
`else
   logic unused_redirect_lsb_s;
   assign unused_redirect_lsb_s = ^redirect_pc[1:0];
   assign halt_s     = 1'b0;
   assign fault_s    = 1'b0;
   assign fault_pc_s = 32'h0000_0000;
`endif

   // A head beat leaving this cycle frees its credit, which keeps a 1-cycle memory streaming
   assign fifo_nonempty_s = (cnt_q != '0);
   assign pop_s           = fifo_nonempty_s && !fault_s && instr_ready && !redirect_valid;
   assign used_s          = {1'b0, infl_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop_s};
   assign credit_s        = (used_s < DEPTH_W);
   assign imem_req_valid  = rst_n && credit_s && !redirect_valid && !halt_s;
   assign imem_addr       = pc_q;
   assign req_fire_s      = imem_req_valid && imem_req_ready;
   assign push_s          = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

   assign instr_valid = fault_s || fifo_nonempty_s;
   assign instr       = fault_s ? NOP_INSTR  : f_data_q[f_rd_q];
   assign instr_pc    = fault_s ? fault_pc_s : f_pc_q[f_rd_q];
   assign fetch_fault = fault_s;

   // Next state for PC, credit/drop counters and buffer pointers; redirect overrides all
   always_comb begin
      pc_d   = pc_q;
      infl_d = infl_q;
      drop_d = drop_q;
      cnt_d  = cnt_q;
      f_wr_d = f_wr_q;
      f_rd_d = f_rd_q;
      q_wr_d = q_wr_q;
      q_rd_d = q_rd_q;
      if (redirect_valid) begin
         pc_d   = redirect_tgt_s;
         // every read still owed is stale, including one arriving right now
         infl_d = imem_rsp_valid ? (infl_q - CW'(1)) : infl_q;
         drop_d = imem_rsp_valid ? (infl_q - CW'(1)) : infl_q;
         cnt_d  = '0;
         f_wr_d = '0;
         f_rd_d = '0;
         q_wr_d = '0;
         q_rd_d = '0;
      end else begin
         if (req_fire_s) begin
            pc_d   = pc_q + 32'd4;
            q_wr_d = idx_inc(q_wr_q);
         end else begin
            pc_d   = pc_q;
            q_wr_d = q_wr_q;
         end
         case ({req_fire_s, imem_rsp_valid})
            2'b10:   infl_d = infl_q + CW'(1);
            2'b01:   infl_d = infl_q - CW'(1);
            default: infl_d = infl_q;
         endcase
         if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end else begin
            drop_d = drop_q;
         end
         if (push_s) begin
            f_wr_d = idx_inc(f_wr_q);
            q_rd_d = idx_inc(q_rd_q);
         end else begin
            f_wr_d = f_wr_q;
            q_rd_d = q_rd_q;
         end
         if (pop_s) begin
            f_rd_d = idx_inc(f_rd_q);
         end else begin
            f_rd_d = f_rd_q;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // State and storage registers; storage is cleared so the head reads zero out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         infl_q <= '0;
         drop_q <= '0;
         cnt_q  <= '0;
         f_wr_q <= '0;
         f_rd_q <= '0;
         q_wr_q <= '0;
         q_rd_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            f_data_q[i] <= 32'h0000_0000;
            f_pc_q[i]   <= 32'h0000_0000;
            pcq_q[i]    <= 32'h0000_0000;
         end
      end else begin
         pc_q   <= pc_d;
         infl_q <= infl_d;
         drop_q <= drop_d;
         cnt_q  <= cnt_d;
         f_wr_q <= f_wr_d;
         f_rd_q <= f_rd_d;
         q_wr_q <= q_wr_d;
         q_rd_q <= q_rd_d;
         if (req_fire_s) begin
            pcq_q[q_wr_q] <= pc_q;
         end
         if (push_s) begin
            f_data_q[f_wr_q] <= imem_rsp_data;
            f_pc_q[f_wr_q]   <= pcq_q[q_rd_q];
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a behavioural memory answers
// requests with addr^key after a programmable latency; stimulus pushes the
// expected {instr, pc, fault} beats, a negedge monitor pops and compares.
module tb_instr_fetch_stage;

   typedef struct { logic [31:0] instr; logic [31:0] pc; logic ff; } exp_t;
   typedef struct { int due; logic [31:0] data; } mrsp_t;
   typedef struct { string name; logic [31:0] act; logic [31:0] want; } chk_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = 32'h0000_0000;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0000_0000;
   logic        instr_valid;
   logic        instr_ready    = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fetch_fault;

   exp_t  exp_q[$];
   mrsp_t mem_q[$];
   chk_t  chk_q[$];
   int    beat_cyc_q[$];

   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   int          beats = 0;
   int          req_cnt = 0;
   int          mem_lat = 1;
   int          r0 = 0;
   int          rc = 0;
   logic [31:0] key = 32'h0000_0000;
   exp_t        mon_e;
   chk_t        mon_c;

   instr_fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // memory: record accepted requests mid-cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         mem_q.delete();
         req_cnt = 0;
      end else if (imem_req_valid && imem_req_ready) begin
         mem_q.push_back('{due: cyc + mem_lat, data: imem_addr ^ key});
         req_cnt = req_cnt + 1;
      end
   end

   // memory: drive responses just after the edge of their due cycle
   always @(posedge clk) begin
      #1;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q[0].data;
         void'(mem_q.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hBAD0_BAD0;
      end
   end

   // monitor: directed checks and scoreboard pops
   always @(negedge clk) begin
      while (chk_q.size() > 0) begin
         mon_c = chk_q.pop_front();
         compared = compared + 1;
         if (mon_c.act !== mon_c.want) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %h, want %h", mon_c.name, mon_c.act, mon_c.want);
         end
      end
      if (!rst_n) begin
         beats = 0;
         beat_cyc_q.delete();
      end else if (instr_valid && instr_ready && !redirect_valid) begin
         beats = beats + 1;
         beat_cyc_q.push_back(cyc);
         compared = compared + 1;
         if (exp_q.size() == 0) begin
            mismatched = mismatched + 1;
            $display("FAIL beat_unexpected: got pc %h instr %h, want no beat", instr_pc, instr);
         end else begin
            mon_e = exp_q.pop_front();
            if (instr !== mon_e.instr || instr_pc !== mon_e.pc || fetch_fault !== mon_e.ff) begin
               mismatched = mismatched + 1;
               $display("FAIL beat: got instr %h pc %h fault %b, want instr %h pc %h fault %b",
                        instr, instr_pc, fetch_fault, mon_e.instr, mon_e.pc, mon_e.ff);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      chk_q.push_back('{name, act, want});
   endtask

   task automatic exp_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{(start + 32'(4 * i)) ^ key, start + 32'(4 * i), 1'b0});
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      rst_n = 1'b1;
      r0    = cyc;
   endtask

   task automatic wait_beats(input int n, input string name);
      int budget;
      budget = 80;
      while (beats < n && budget > 0) begin
         tick();
         budget = budget - 1;
      end
      chk(name, 32'(beats >= n), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // T1: reset values, then streaming one beat per cycle, instr == pc
      rst_n = 1'b0;
      key = 32'h0000_0000; mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0000_0000);
      chk("rst_instr_pc", instr_pc, 32'h0000_0000);
      chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
      do_reset();
      exp_seq(32'h0000_0000, 12);
      @(negedge clk);
      chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t1_first_req_addr", imem_addr, 32'h0000_0000);
      wait_beats(8, "t1_beats_timeout");
      instr_ready = 1'b0;
      chk("t1_beat_count", 32'(beat_cyc_q.size() >= 4), 32'd1);
      if (beat_cyc_q.size() >= 4) begin
         chk("t1_first_beat_cycle", 32'(beat_cyc_q[0] - r0), 32'd2);
         for (int i = 1; i < 4; i++) begin
            chk("t1_beat_spacing", 32'(beat_cyc_q[i] - beat_cyc_q[i-1]), 32'd1);
         end
      end

      // T2: decoder stalled -> credit limit, then in-order drain
      key = 32'hCAFE_0000; instr_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      @(negedge clk);
      chk("t2_req_count", 32'(req_cnt), 32'd2);
      chk("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
      chk("t2_head_valid", 32'(instr_valid), 32'd1);
      chk("t2_head_pc", instr_pc, 32'h0000_0000);
      chk("t2_head_instr", instr, 32'hCAFE_0000);
      exp_seq(32'h0000_0000, 12);
      tick();
      instr_ready = 1'b1;
      wait_beats(8, "t2_beats_timeout");
      instr_ready = 1'b0;

      // T3: latency 3, redirect with two reads in flight
      key = 32'h5A5A_0000; mem_lat = 3; instr_ready = 1'b1;
      do_reset();
      exp_seq(32'h0000_0100, 12);
      tick();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      @(negedge clk);
      chk("t3_inflight_before_redirect", 32'(req_cnt), 32'd2);
      chk("t3_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      wait_beats(6, "t3_beats_timeout");
      instr_ready = 1'b0;

      // T4: memory back-pressure holds the request; redirect retargets it
      key = 32'h1111_0000; mem_lat = 1; imem_req_ready = 1'b0; instr_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(imem_req_valid), 32'd1);
         chk("t4_hold_addr", imem_addr, 32'h0000_0000);
         tick();
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      @(negedge clk);
      chk("t4_withdraw_on_redirect", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_new_addr", imem_addr, 32'h0000_0040);
      chk("t4_new_valid", 32'(imem_req_valid), 32'd1);
      exp_seq(32'h0000_0040, 12);
      tick();
      imem_req_ready = 1'b1;
      wait_beats(6, "t4_beats_timeout");
      instr_ready = 1'b0;

      // T5: reset with the buffer full, then restart at the reset PC
      key = 32'h7777_0000; mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
      do_reset();
      repeat (4) tick();
      @(negedge clk);
      chk("t5_full_valid", 32'(instr_valid), 32'd1);
      chk("t5_full_stall", 32'(imem_req_valid), 32'd0);
      chk("t5_full_head_pc", instr_pc, 32'h0000_0000);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_async_clear_valid", 32'(instr_valid), 32'd0);
      chk("t5_async_clear_instr", instr, 32'h0000_0000);
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      rst_n = 1'b1;
      r0 = cyc;
      @(negedge clk);
      chk("t5_restart_valid", 32'(imem_req_valid), 32'd1);
      chk("t5_restart_addr", imem_addr, 32'h0000_0000);
      exp_seq(32'h0000_0000, 12);
      tick();
      instr_ready = 1'b1;
      wait_beats(4, "t5_beats_timeout");
      instr_ready = 1'b0;

`ifdef IF_MISALIGN_CHK_EN
      // T6: misaligned redirect -> one NOP fault beat, halt, recover on aligned redirect
      key = 32'h2222_0000; mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
      do_reset();
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      tick();
      redirect_valid = 1'b0;
      rc = req_cnt;
      @(negedge clk);
      chk("t6_fault_valid", 32'(instr_valid), 32'd1);
      chk("t6_fault_instr", instr, 32'h0000_0013);
      chk("t6_fault_pc", instr_pc, 32'h0000_0102);
      chk("t6_fault_flag", 32'(fetch_fault), 32'd1);
      chk("t6_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("t6_fault_held", 32'(fetch_fault), 32'd1);
      tick();
      exp_q.push_back('{32'h0000_0013, 32'h0000_0102, 1'b1});
      instr_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      chk("t6_halt_no_valid", 32'(instr_valid), 32'd0);
      chk("t6_halt_no_req", 32'(imem_req_valid), 32'd0);
      chk("t6_halt_req_count", 32'(req_cnt), 32'(rc));
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      exp_seq(32'h0000_0200, 12);
      wait_beats(7, "t6_beats_timeout");
      instr_ready = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
